// File: rtl/intpol2_d4_ctrl.sv
// Sequencer for the 2nd-order interpolator: fills a 3-sample window, steps the
// phase accumulator and hands (window, mu) pairs to the polynomial stage.
module intpol2_d4_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int N_bits       = 2,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear,
  input  logic                         start,
  input  logic                         stop,
  input  logic [DATA_WIDTH+N_bits-1:0] step,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [SAMPLE_WIDTH-1:0]      s_data,
  output logic                         acc_clear,
  output logic                         acc_en,
  output logic [DATA_WIDTH+N_bits-1:0] acc_x,
  input  logic [DATA_WIDTH+N_bits-1:0] acc_xi,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [SAMPLE_WIDTH-1:0]      o_p0,
  output logic [SAMPLE_WIDTH-1:0]      o_p1,
  output logic [SAMPLE_WIDTH-1:0]      o_p2,
  output logic [DATA_WIDTH-1:0]        o_mu,
  output logic                         busy,
  output logic                         err
);

  localparam int W = DATA_WIDTH + N_bits;
  localparam logic [W-1:0] ONE     = W'(1) << DATA_WIDTH;
  localparam logic [W-1:0] NEG_ONE = ~ONE + W'(1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    CHECK,
    SHIFT
  } state_t;

  state_t                  state;
  logic [W-1:0]            step_q;
  logic [1:0]              fill_cnt;
  logic [SAMPLE_WIDTH-1:0] p0_q, p1_q, p2_q;

  logic step_bad;
  logic s_hs;
  logic o_hs;
  logic start_ok;

  // NOTE: handshake outputs are decoded combinationally from the state so a
  // transfer completes in the cycle it is offered; clear masks them so an abort
  // never moves the window or the accumulator.
  assign step_bad = (step == '0) || (step > ONE);
  assign s_ready  = !clear && ((state == FILL) || (state == SHIFT));
  assign o_valid  = !clear && (state == RUN);
  assign s_hs     = s_valid && s_ready;
  assign o_hs     = o_valid && o_ready;
  assign start_ok = (state == IDLE) && start && !stop && !step_bad;

  assign acc_clear = clear || start_ok;
  assign acc_en    = o_hs || (s_hs && (state == SHIFT));
  assign busy      = (state != IDLE);

  assign o_p0 = p0_q;
  assign o_p1 = p1_q;
  assign o_p2 = p2_q;
  assign o_mu = acc_xi[DATA_WIDTH-1:0];

  always_comb begin
    acc_x = '0;
    if (o_hs)
      acc_x = step_q;
    else if (s_hs && (state == SHIFT))
      acc_x = NEG_ONE;
  end

  // NOTE: every register here, window included, uses <= and is cleared by the
  // async reset so the block leaves reset with all-zero outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      step_q   <= '0;
      fill_cnt <= '0;
      p0_q     <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      err      <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      if (s_hs) begin
        p0_q <= p1_q;
        p1_q <= p2_q;
        p2_q <= s_data;
      end

      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            if (step_bad) begin
              err <= 1'b1;
            end else begin
              err      <= 1'b0;
              step_q   <= step;
              fill_cnt <= '0;
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (s_hs) begin
            fill_cnt <= fill_cnt + 2'd1;
            if (fill_cnt == 2'd2)
              state <= RUN;
          end
        end
        RUN: begin
          if (o_hs)
            state <= CHECK;
        end
        CHECK: begin
          // acc_xi already includes the increment issued in the previous cycle
          if (acc_xi[W-1:DATA_WIDTH] != '0)
            state <= SHIFT;
          else
            state <= RUN;
        end
        SHIFT: begin
          if (s_hs)
            state <= CHECK;
        end
        default: state <= IDLE;
      endcase

      if (stop)
        state <= IDLE;
    end
  end

endmodule

// File: tb/tb_intpol2_d4_ctrl.sv
// Directed bench for intpol2_d4_ctrl with a behavioural phase accumulator;
// expected windows and phases are hand-computed constants.
module tb_intpol2_d4_ctrl;

  localparam int DW = 8;
  localparam int NB = 2;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          clear, start, stop;
  logic [9:0]    step;
  logic          s_valid, s_ready;
  logic [SW-1:0] s_data;
  logic          acc_clear, acc_en;
  logic [9:0]    acc_x, acc_xi;
  logic          o_valid, o_ready;
  logic [SW-1:0] o_p0, o_p1, o_p2;
  logic [DW-1:0] o_mu;
  logic          busy, err;

  int checks = 0;
  int errors = 0;

  logic [55:0] got_q[$];
  logic [55:0] exp_q[$];
  logic [9:0]  ax_q[$];
  int          consumed, stray_en, starve_left, starve_seen, starve_bad;
  int          stall_bad, first_ov;
  logic        stalled;
  logic [55:0] held;

  intpol2_d4_ctrl #(.DATA_WIDTH(DW), .N_bits(NB), .SAMPLE_WIDTH(SW)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .start(start), .stop(stop),
    .step(step), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .acc_clear(acc_clear), .acc_en(acc_en), .acc_x(acc_x), .acc_xi(acc_xi),
    .o_valid(o_valid), .o_ready(o_ready), .o_p0(o_p0), .o_p1(o_p1),
    .o_p2(o_p2), .o_mu(o_mu), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Downstream phase accumulator
  always @(posedge clk or negedge rstn) begin
    if (!rstn)          acc_xi <= '0;
    else if (acc_clear) acc_xi <= '0;
    else if (acc_en)    acc_xi <= acc_xi + acc_x;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_win(input int p0, input int p1, input int p2, input int mu);
    exp_q.push_back({p0[15:0], p1[15:0], p2[15:0], mu[7:0]});
  endtask

  task automatic cmp_wins(input string tag);
    logic [55:0] g;
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : '1;
      check($sformatf("%s_w%0d", tag, i), g, exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic new_run(input int d0);
    got_q.delete();
    ax_q.delete();
    s_data   = d0[15:0];
    consumed = 0;
    stalled  = 1'b0;
    first_ov = -1;
  endtask

  task automatic do_start(input logic [9:0] st, input logic exp_clr, input string tag);
    @(negedge clk);
    start = 1'b1; step = st; s_valid = 1'b0; o_ready = 1'b0;
    #1 check({tag, "_accclr"}, acc_clear, exp_clr);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1; s_valid = 1'b0; o_ready = 1'b0;
    #1 check("stop_no_accclr", acc_clear, 1'b0);
    @(posedge clk);
    #1 stop = 1'b0;
    check("stop_idle", busy, 1'b0);
  endtask

  // One iteration per cycle: drive, sample between edges, advance source after edge
  task automatic run(input int n, input bit toggle_ready);
    logic hs;
    logic [55:0] cur;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o_ready = toggle_ready ? i[0] : 1'b1;
      #1;
      if (s_ready && consumed >= 3 && starve_left > 0) begin
        s_valid = 1'b0;
        starve_left--;
        starve_seen++;
      end else begin
        s_valid = 1'b1;
      end
      #1;
      cur = {o_p0, o_p1, o_p2, o_mu};
      if (!s_valid && s_ready && o_valid) starve_bad++;
      if (o_valid && first_ov < 0) first_ov = i;
      if (stalled && (!o_valid || cur != held)) stall_bad++;
      stalled = o_valid && !o_ready;
      held    = cur;
      if (o_valid && o_ready) got_q.push_back(cur);
      if (acc_en && !(o_valid && o_ready) && !(s_valid && s_ready)) stray_en++;
      if (acc_en) ax_q.push_back(acc_x);
      hs = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        s_data++;
        consumed++;
      end
    end
  endtask

  initial begin
    rstn = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0; step = '0;
    s_valid = 1'b0; o_ready = 1'b0; s_data = '0;
    stray_en = 0; starve_left = 0; starve_seen = 0; starve_bad = 0; stall_bad = 0;
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ovalid", o_valid, 1'b0);
    check("rst_sready", s_ready, 1'b0);
    check("rst_acc_x", acc_x, '0);
    check("rst_win", {o_p0, o_p1, o_p2, o_mu}, '0);
    @(negedge clk);
    rstn = 1'b1;

    // L=2
    new_run(1);
    do_start(10'h080, 1'b1, "l2");
    run(14, 1'b0);
    check("l2_first_ovalid", first_ov, 3);
    expect_win(1, 2, 3, 8'h00); expect_win(1, 2, 3, 8'h80);
    expect_win(2, 3, 4, 8'h00); expect_win(2, 3, 4, 8'h80);
    cmp_wins("l2");
    check("l2_ax0", (ax_q.size() > 0) ? ax_q[0] : 10'h3ff, 10'h080);
    check("l2_ax2_shift", (ax_q.size() > 2) ? ax_q[2] : 10'h3ff, 10'h300);
    do_stop();

    // L=4 with toggling o_ready
    new_run(1);
    do_start(10'h040, 1'b1, "l4");
    run(30, 1'b1);
    expect_win(1, 2, 3, 8'h00); expect_win(1, 2, 3, 8'h40);
    expect_win(1, 2, 3, 8'h80); expect_win(1, 2, 3, 8'hC0);
    expect_win(2, 3, 4, 8'h00);
    cmp_wins("l4");
    check("l4_stall_stable", stall_bad, 0);
    do_stop();

    // step = ONE
    new_run(1);
    do_start(10'h100, 1'b1, "one");
    run(18, 1'b0);
    expect_win(1, 2, 3, 8'h00); expect_win(2, 3, 4, 8'h00); expect_win(3, 4, 5, 8'h00);
    cmp_wins("one");
    check("one_ax1_shift", (ax_q.size() > 1) ? ax_q[1] : 10'h3ff, 10'h300);
    do_stop();

    // Illegal steps, then a legal one
    do_start(10'h000, 1'b0, "ill0");
    check("ill0_err", err, 1'b1);
    check("ill0_busy", busy, 1'b0);
    do_start(10'h101, 1'b0, "ill101");
    check("ill101_err", err, 1'b1);
    check("ill101_busy", busy, 1'b0);
    new_run(1);
    do_start(10'h080, 1'b1, "legal");
    check("legal_err", err, 1'b0);
    check("legal_busy", busy, 1'b1);
    do_stop();

    // Input starvation in SHIFT
    new_run(1);
    starve_seen = 0;
    starve_left = 5;
    do_start(10'h080, 1'b1, "stv");
    run(28, 1'b0);
    check("stv_cycles", starve_seen, 5);
    check("stv_ovalid_low", starve_bad, 0);
    expect_win(1, 2, 3, 8'h00); expect_win(1, 2, 3, 8'h80);
    expect_win(2, 3, 4, 8'h00); expect_win(2, 3, 4, 8'h80);
    expect_win(3, 4, 5, 8'h00);
    cmp_wins("stv");
    do_stop();

    // clear in CHECK
    new_run(1);
    do_start(10'h080, 1'b1, "clr");
    run(4, 1'b0);
    @(negedge clk);
    clear = 1'b1; s_valid = 1'b1; o_ready = 1'b1;
    #1;
    check("clr_accclr", acc_clear, 1'b1);
    check("clr_ovalid", o_valid, 1'b0);
    check("clr_acc_en", acc_en, 1'b0);
    @(posedge clk);
    #1 clear = 1'b0; s_valid = 1'b0;
    check("clr_idle", busy, 1'b0);
    check("clr_win_kept", {o_p0, o_p1, o_p2}, {16'd1, 16'd2, 16'd3});

    // stop in FILL with a sample handshake in the same cycle
    new_run(10);
    do_start(10'h080, 1'b1, "stp");
    run(1, 1'b0);
    @(negedge clk);
    stop = 1'b1; s_valid = 1'b1; o_ready = 1'b0;
    #1;
    check("stp_sready", s_ready, 1'b1);
    check("stp_no_accclr", acc_clear, 1'b0);
    @(posedge clk);
    #1 stop = 1'b0; s_valid = 1'b0;
    check("stp_idle", busy, 1'b0);
    check("stp_win", {o_p0, o_p1, o_p2}, {16'd3, 16'd10, 16'd11});

    // reset while holding in SHIFT
    new_run(1);
    starve_left = 3;
    do_start(10'h100, 1'b1, "rsh");
    run(6, 1'b0);
    check("rsh_in_shift", {busy, s_ready, o_valid}, 3'b110);
    starve_left = 0;
    #2 rstn = 1'b0;
    #1;
    check("rsh_busy", busy, 1'b0);
    check("rsh_ctrl", {s_ready, o_valid, acc_clear, acc_en, err}, 5'b0);
    check("rsh_acc_x", acc_x, '0);
    check("rsh_win", {o_p0, o_p1, o_p2, o_mu}, '0);
    @(negedge clk);
    rstn = 1'b1;

    check("no_stray_acc_en", stray_en, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intpol2_d4_ctrl.md
# intpol2_D4_ctrl

Sequencer for the 2nd-order interpolator datapath. It sits directly upstream of `intpol2_D4_mult_by_add`, the phase accumulator, and drives that block's `clear`, `en` and `x` inputs. It reads back the accumulator output `xi`, keeps a 3-sample window (p0, p1, p2) filled from the input stream, and presents each window with its fractional phase `mu` to the polynomial stage downstream. Phase format is unsigned fixed point Q(N_bits).(DATA_WIDTH); ONE = 1 << DATA_WIDTH.

## Interface
- `DATA_WIDTH`, 32, fractional bits of phase/step (matches accumulator)
- `N_bits`, 2, integer bits of phase/step (matches accumulator)
- `SAMPLE_WIDTH`, 16, width of input samples
- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous abort: return to IDLE, pulse `acc_clear`
- `start`  in  1  begin a run; ignored unless IDLE
- `stop`  in  1  end a run; state is IDLE next cycle
- `step`  in  DATA_WIDTH+N_bits  phase increment per output (1/L); latched on accepted `start`
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  input sample accepted when `s_valid && s_ready`
- `s_data`  in  SAMPLE_WIDTH  input sample
- `acc_clear`  out  1  to accumulator `clear`
- `acc_en`  out  1  to accumulator `en`
- `acc_x`  out  DATA_WIDTH+N_bits  to accumulator `x`
- `acc_xi`  in  DATA_WIDTH+N_bits  from accumulator `xi`
- `o_valid`  out  1  window/phase valid
- `o_ready`  in  1  downstream accept
- `o_p0`, `o_p1`, `o_p2`  out  SAMPLE_WIDTH each  window, oldest to newest
- `o_mu`  out  DATA_WIDTH  `acc_xi[DATA_WIDTH-1:0]`
- `busy`  out  1  state != IDLE
- `err`  out  1  sticky: last `start` carried an illegal step

## Operation
- States: IDLE, FILL, RUN, CHECK, SHIFT.
- IDLE: `s_ready`=0, `o_valid`=0. On `start`, check the step. If `step==0` or `step>ONE`: set `err`, remain IDLE. Otherwise: clear `err`, latch the step, drive `acc_clear`=1 for this cycle, clear the fill counter, go to FILL.
- FILL: `s_ready`=1. On each input handshake: p0<=p1, p1<=p2, p2<=s_data, counter++. The third handshake moves the state to RUN.
- RUN: `o_valid`=1. On output handshake: `acc_en`=1, `acc_x`=latched step, go to CHECK.
- CHECK: `o_valid`=0, `s_ready`=0. Integer part `acc_xi[DATA_WIDTH+N_bits-1:DATA_WIDTH]`: zero goes to RUN, non-zero goes to SHIFT.
- SHIFT: `s_ready`=1. On input handshake: shift the window as in FILL, `acc_en`=1, `acc_x`=-ONE (two's complement, DATA_WIDTH+N_bits wide), go to CHECK.
- `acc_en`=0 and `acc_x`=0 in every cycle without the handshakes above.
- Priority: `rstn` > `clear` > `stop` > `start`/handshakes.
- `clear`: next state IDLE, `acc_clear`=1 in the same cycle, the window registers keep their values, `err` is kept.
- `stop`: any handshake in that cycle completes normally, including its `acc_en`; next state is IDLE regardless. The accumulator is left unchanged; the next `start` clears it.
- Step rule: 0 < step ≤ ONE, so the integer part after one increment is ≤1 and one SHIFT per CHECK is enough. The CHECK/SHIFT loop stays generic anyway.

## Timing
- Reset: state IDLE; `s_ready`, `o_valid`, `acc_clear`, `acc_en`, `busy`, `err` = 0; `acc_x`, `o_p0..2`, `o_mu` and the latched step = 0.
- All control outputs are combinational from the state and the handshake inputs. The window, step, counter and `err` are registered.
- The accumulator is registered: `acc_xi` reflects an `acc_en` from cycle T at cycle T+1, which is the CHECK cycle.
- `start` to first `o_valid`: 1 + 3 input handshakes. With `s_valid` held high, `o_valid` rises 4 cycles after `start`.
- Output throughput is at most one window per 2 cycles (RUN + CHECK). A sample advance adds SHIFT + CHECK.
- `o_p*` and `o_mu` stay stable while `o_valid && !o_ready`.

## Test plan
DATA_WIDTH=8, N_bits=2, SAMPLE_WIDTH=16, ONE=0x100.
- Basic L=2: step=0x080, inputs 1,2,3,4,…, `o_ready`=1 → (p0,p1,p2,mu) = (1,2,3,0x00), (1,2,3,0x80), (2,3,4,0x00), (2,3,4,0x80). The SHIFT cycles show `acc_x`=0x300.
- L=4 with backpressure: step=0x040, `o_ready` toggling → mu sequence 0x00,0x40,0x80,0xC0 then window shift. Outputs stay stable while stalled. No `acc_en` without a handshake.
- Step=ONE: step=0x100 → every output is followed by SHIFT; mu is always 0x00; windows (1,2,3), (2,3,4), (3,4,5).
- Illegal step: start with step=0x000 and then step=0x101 → `err`=1, `busy`=0, no `acc_clear`. A following start with step=0x080 sets `err`=0 and pulses `acc_clear`.
- Input starvation: `s_valid`=0 during SHIFT for 5 cycles → `o_valid` stays 0, the state holds in SHIFT, and the stream resumes correctly.
- Abort: `clear` asserted in CHECK, then `stop` asserted during FILL → IDLE on the next cycle in both cases. `acc_clear`=1 only for `clear`. `rstn` pulled low mid-SHIFT gives all-zero outputs immediately.
